// File: rtl/text_overlay_pkg.sv
// Shared definitions for the text tile overlay: cell entry layout, geometry and FSM states.
package text_overlay_pkg;

    localparam int ENTRY_W   = 11;
    localparam int CHAR_MSB  = 6;
    localparam int RGB_LSB   = 7;
    localparam int BLINK_BIT = 10;

    localparam logic [ENTRY_W-1:0] BLANK_ENTRY = 11'h000;
    localparam logic [2:0]         BG_RGB      = 3'b111;

    localparam int CELL_W_LOG2 = 4;
    localparam int CELL_H_LOG2 = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/font_rom.sv
// 8x16 character generator ROM with registered output; addr = {char, glyph_row}, MSB is leftmost pixel.
module font_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [7:0] rom_word;

    always_comb begin
        rom_word = 8'h00;
        case (addr)
            11'h412: rom_word = 8'h10;
            11'h413: rom_word = 8'h38;
            11'h414: rom_word = 8'h6c;
            11'h415: rom_word = 8'hc6;
            11'h416: rom_word = 8'hc6;
            11'h417: rom_word = 8'hfe;
            11'h418: rom_word = 8'hc6;
            11'h419: rom_word = 8'hc6;
            11'h41a: rom_word = 8'hc6;
            11'h41b: rom_word = 8'hc6;
            default: rom_word = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= rom_word;
    end

endmodule

// File: rtl/text_tile_ram.sv
// Simple dual-port tile buffer: one write port, one registered read-first read port.
module text_tile_ram #(
    parameter int DEPTH = 240,
    parameter int AW    = 8,
    parameter int W     = 11
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/text_tile_overlay.sv
// RAM-backed character overlay for the VGA pixel path with per-cell colour.
// Optional blink attribute enabled by defining TEXT_OVERLAY_BLINK_EN.
module text_tile_overlay
    import text_overlay_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int ROWS         = 15,
    parameter int BLINK_FRAMES = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [9:0]   pix_x,
    input  logic [9:0]   pix_y,
    input  logic         frame_tick,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [3:0]   wr_row,
    input  logic [5:0]   wr_col,
    input  logic [10:0]  wr_data,
    input  logic         clear_req,
    output logic         clear_busy,
    output logic         text_on,
    output logic [2:0]   text_rgb
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_q == AW'(CELLS - 1)) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign wr_ready   = (state_q == ST_IDLE);
    assign clear_busy = (state_q == ST_CLEAR);

    // Out-of-range writes still complete the handshake but never reach the RAM.
    logic               wr_in_range;
    logic [AW-1:0]      wr_addr;
    logic [ENTRY_W-1:0] wr_entry;
    logic               ram_we;
    logic [AW-1:0]      ram_waddr;
    logic [ENTRY_W-1:0] ram_wdata;

    assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign wr_addr     = AW'(int'(wr_row) * COLS + int'(wr_col));
`ifdef TEXT_OVERLAY_BLINK_EN
    assign wr_entry    = wr_data;
`else
    assign wr_entry    = {1'b0, wr_data[BLINK_BIT-1:0]};
`endif
    assign ram_we    = clear_busy || (wr_valid && wr_ready && wr_in_range);
    assign ram_waddr = clear_busy ? clr_idx_q : wr_addr;
    assign ram_wdata = clear_busy ? BLANK_ENTRY : wr_entry;

    logic [5:0]         cell_col;
    logic [4:0]         cell_row;
    logic               in_window;
    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] rd_entry;

    assign cell_col  = pix_x[9:CELL_W_LOG2];
    assign cell_row  = pix_y[9:CELL_H_LOG2];
    assign in_window = (int'(cell_col) < COLS) && (int'(cell_row) < ROWS);
    assign rd_addr   = AW'(int'(cell_row) * COLS + int'(cell_col));

    text_tile_ram #(
        .DEPTH (CELLS),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_tile_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_entry)
    );

    logic       win1_q;
    logic [2:0] gbit1_q;
    logic [3:0] grow1_q;
    logic       win2_q;
    logic [2:0] gbit2_q;
    logic [2:0] rgb2_q;
    logic       vis2_q;
    logic       visible;
    logic [7:0] font_word;

    font_rom u_font_rom (
        .clk  (clk),
        .addr ({rd_entry[CHAR_MSB:0], grow1_q}),
        .data (font_word)
    );

    // Stage 2 registers line up with font_word, which the ROM registers on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            win1_q  <= 1'b0;
            gbit1_q <= '0;
            grow1_q <= '0;
            win2_q  <= 1'b0;
            gbit2_q <= '0;
            rgb2_q  <= BG_RGB;
            vis2_q  <= 1'b0;
        end else begin
            win1_q  <= in_window;
            gbit1_q <= pix_x[3:1];
            grow1_q <= pix_y[4:1];
            win2_q  <= win1_q;
            gbit2_q <= gbit1_q;
            rgb2_q  <= rd_entry[RGB_LSB +: 3];
            vis2_q  <= visible;
        end
    end

    assign text_on  = win2_q;
    assign text_rgb = (win2_q && vis2_q && font_word[~gbit2_q]) ? rgb2_q : BG_RGB;

`ifdef TEXT_OVERLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt_q;
    logic          phase_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign visible = !rd_entry[BLINK_BIT] || phase_q;
`else
    logic unused_blink;
    assign unused_blink = ^{frame_tick, wr_data[BLINK_BIT], rd_entry[BLINK_BIT]};
    assign visible      = 1'b1;
`endif

    logic unused_pix;
    assign unused_pix = ^{pix_x[0], pix_y[0]};

endmodule

// File: tb/tb_text_tile_overlay.sv
// Scoreboard bench for text_tile_overlay: pixel expectations queued at drive time, checked two cycles later.
module tb_text_tile_overlay;

    localparam int COLS  = 16;
    localparam int ROWS  = 15;
    localparam int BF    = 2;
    localparam int CELLS = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        frame_tick = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_row = '0;
    logic [5:0]  wr_col = '0;
    logic [10:0] wr_data = '0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        text_on;
    logic [2:0]  text_rgb;

    always #5 clk = ~clk;

    text_tile_overlay #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_tick (frame_tick),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .text_on    (text_on),
        .text_rgb   (text_rgb)
    );

    typedef struct packed {
        logic       on;
        logic [2:0] rgb;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [10:0] cells [ROWS][COLS];
    int          m_cnt = 0;
    logic        m_phase = 1'b1;
    exp_t        exp_q[$];

    function automatic logic [7:0] font_model(input logic [6:0] ch, input int r);
        logic [7:0] w;
        w = 8'h00;
        if (ch == 7'h41) begin
            case (r)
                2:       w = 8'h10;
                3:       w = 8'h38;
                4:       w = 8'h6c;
                7:       w = 8'hfe;
                5, 6, 8, 9, 10, 11: w = 8'hc6;
                default: w = 8'h00;
            endcase
        end
        return w;
    endfunction

    function automatic exp_t expect_px(input int x, input int y);
        exp_t        e;
        int          col, row;
        logic [10:0] ent;
        logic [7:0]  fw;
        logic        b, vis;
        e.x = 10'(x);
        e.y = 10'(y);
        col = x / 16;
        row = y / 32;
        if (col >= COLS || row >= ROWS) begin
            e.on  = 1'b0;
            e.rgb = 3'b111;
        end else begin
            ent   = cells[row][col];
            fw    = font_model(ent[6:0], (y / 2) % 16);
            b     = fw[7 - ((x / 2) % 8)];
            vis   = !ent[10] || m_phase;
            e.on  = 1'b1;
            e.rgb = (b && vis) ? ent[9:7] : 3'b111;
        end
        return e;
    endfunction

    function automatic logic [10:0] stored(input logic [10:0] d);
`ifdef TEXT_OVERLAY_BLINK_EN
        return d;
`else
        return {1'b0, d[9:0]};
`endif
    endfunction

    task automatic model_reset();
        foreach (cells[i, j]) cells[i][j] = 11'h000;
        m_cnt   = 0;
        m_phase = 1'b1;
    endtask

    // Drive a rectangle of pixels; each output is compared two cycles after its coordinate.
    task automatic scan(input int x0, input int x1, input int xs,
                        input int y0, input int y1, input int ys);
        int   w, h, n;
        exp_t e;
        w = (x1 - x0) / xs + 1;
        h = (y1 - y0) / ys + 1;
        n = w * h;
        exp_q.delete();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                e = exp_q.pop_front();
                tests_run++;
                if (text_on !== e.on || text_rgb !== e.rgb) begin
                    tests_failed++;
                    $display("FAIL render x=%0d y=%0d: got on=%b rgb=%b, expected on=%b rgb=%b",
                             e.x, e.y, text_on, text_rgb, e.on, e.rgb);
                end
            end
            if (k < n) begin
                pix_x = 10'(x0 + (k % w) * xs);
                pix_y = 10'(y0 + (k / w) * ys);
                exp_q.push_back(expect_px(x0 + (k % w) * xs, y0 + (k / w) * ys));
            end
        end
    endtask

    task automatic do_write(input int row, input int col, input logic [10:0] data);
        int n;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_row   = 4'(row);
        wr_col   = 6'(col);
        wr_data  = data;
        n = 0;
        while (!wr_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        tests_run++;
        if (n >= 1000) begin
            tests_failed++;
            $display("FAIL write_handshake row=%0d col=%0d: wr_ready stayed %b, required 1", row, col, wr_ready);
        end
        if (row < ROWS && col < COLS) cells[row][col] = stored(data);
        $display("[TB] write row=%0d col=%0d data=%03h after %0d wait cycles", row, col, data, n);
    endtask

    task automatic write_idle();
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (m_cnt == BF - 1) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        tests_run += 4;
        if (wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wr_ready: got %b, expected 0", wr_ready);
        end
        if (clear_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_clear_busy: got %b, expected 1", clear_busy);
        end
        if (text_on !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_text_on: got %b, expected 0", text_on);
        end
        if (text_rgb !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_text_rgb: got %b, expected 111", text_rgb);
        end
        reset = 1'b0;
        model_reset();
        cnt = 0;
        while (!wr_ready && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        tests_run += 2;
        if (cnt != CELLS) begin
            tests_failed++;
            $display("FAIL post_reset_clear_len: got %0d cycles, expected %0d", cnt, CELLS);
        end
        if (clear_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_busy: got %b, expected 0", clear_busy);
        end
        $display("[TB] post-reset clear lasted %0d cycles", cnt);
        scan(0, 270, 7, 0, 490, 9);
        scan(250, 260, 1, 475, 484, 1);
    endtask

    task automatic test_basic_render();
        do_write(2, 3, {1'b0, 3'b001, 7'h41});
        do_write(2, 4, {1'b0, 3'b110, 7'h41});
        write_idle();
        scan(44, 83, 1, 62, 97, 1);
    endtask

    task automatic test_out_of_range();
        do_write(15, 0, {1'b0, 3'b010, 7'h41});
        do_write(0, 16, {1'b0, 3'b010, 7'h41});
        do_write(1, 63, {1'b0, 3'b011, 7'h41});
        write_idle();
        scan(0, 31, 1, 16, 63, 1);
        scan(240, 255, 1, 448, 479, 2);
    endtask

    task automatic test_clear_collision();
        int cnt;
        do_write(0, 1, {1'b0, 3'b011, 7'h41});
        write_idle();
        @(negedge clk);
        wr_valid  = 1'b1;
        wr_row    = 4'd0;
        wr_col    = 6'd2;
        wr_data   = {1'b0, 3'b101, 7'h41};
        clear_req = 1'b1;
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_ready: got %b, expected 1", wr_ready);
        end
        @(negedge clk);
        clear_req = 1'b0;
        wr_col    = 6'd3;
        wr_data   = {1'b0, 3'b110, 7'h41};
        cnt = 0;
        // A second clear request arrives mid-clear and must not restart it.
        while (!wr_ready && cnt < 1000) begin
            cnt++;
            clear_req = (cnt == 100);
            @(negedge clk);
        end
        clear_req = 1'b0;
        tests_run += 2;
        if (cnt != CELLS) begin
            tests_failed++;
            $display("FAIL collision_clear_len: got %0d cycles, expected %0d", cnt, CELLS);
        end
        if (clear_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_busy_end: got %b, expected 0", clear_busy);
        end
        @(posedge clk);
        model_reset_cells_only();
        cells[0][3] = stored({1'b0, 3'b110, 7'h41});
        $display("[TB] clear with held write lasted %0d cycles", cnt);
        write_idle();
        scan(0, 79, 1, 0, 31, 1);
    endtask

    task automatic model_reset_cells_only();
        foreach (cells[i, j]) cells[i][j] = 11'h000;
    endtask

    task automatic test_blink();
        do_write(3, 5, {1'b1, 3'b100, 7'h41});
        do_write(3, 6, {1'b0, 3'b010, 7'h41});
        write_idle();
        for (int f = 0; f < 6; f++) begin
            $display("[TB] blink frame %0d phase=%b", f, m_phase);
            scan(80, 111, 1, 96, 127, 1);
            pulse_tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        while (!wr_ready && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        tests_run += 2;
        if (cnt != CELLS) begin
            tests_failed++;
            $display("FAIL mid_clear_restart_len: got %0d cycles, expected %0d", cnt, CELLS);
        end
        if (clear_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_clear_busy_end: got %b, expected 0", clear_busy);
        end
        $display("[TB] restarted clear lasted %0d cycles", cnt);
        scan(0, 270, 7, 0, 490, 9);
    endtask

    initial begin
        test_reset();
        test_basic_render();
        test_out_of_range();
        test_clear_collision();
        test_blink();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
